// File: rtl/lsu_pkg.sv
// Shared encodings, address map and FSM state type for the LSU bus master.
package lsu_pkg;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [31:0] DM_BASE   = 32'h0000_0000;
    localparam logic [31:0] DM_LAST   = 32'h0000_2fff;
    localparam logic [31:0] TMR_BASE  = 32'h0000_7f00;
    localparam logic [31:0] T0_BASE   = 32'h0000_7f00;
    localparam logic [31:0] T0_LAST   = 32'h0000_7f0b;
    localparam logic [31:0] T1_BASE   = 32'h0000_7f10;
    localparam logic [31:0] T1_LAST   = 32'h0000_7f1b;
    localparam logic [31:0] T0_COUNT_OFS = 32'h0000_0008;
    localparam logic [31:0] T1_COUNT_OFS = 32'h0000_0018;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } lsu_state_e;

    // DM starts at address 0, so only its upper bound needs a compare.
    function automatic logic [4:0] access_exc(logic [2:0] ld, logic [1:0] st, logic [31:0] a);
        logic in_tmr;
        logic in_map;
        logic ld_mis;
        logic st_mis;
        logic cnt_reg;
        in_tmr  = (a >= T0_BASE && a <= T0_LAST) || (a >= T1_BASE && a <= T1_LAST);
        in_map  = (a <= DM_LAST) || in_tmr;
        ld_mis  = (ld == LD_LW && a[1:0] != 2'b00) || ((ld == LD_LH || ld == LD_LHU) && a[0]);
        st_mis  = (st == ST_SW && a[1:0] != 2'b00) || (st == ST_SH && a[0]);
        cnt_reg = (a == TMR_BASE + T0_COUNT_OFS) || (a == TMR_BASE + T1_COUNT_OFS);
        access_exc = EXC_NONE;
        if (ld != LD_NONE) begin
            if (ld_mis || !in_map || (in_tmr && ld != LD_LW))
                access_exc = EXC_ADEL;
        end else if (st != ST_NONE) begin
            if (st_mis || !in_map || (in_tmr && st != ST_SW) || (st == ST_SW && cnt_reg))
                access_exc = EXC_ADES;
        end
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / lane replication and load extraction with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  load_op,
    input  logic [1:0]  store_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case statements infers a latch.
        be        = 4'b0000;
        wdata_rep = 32'h0;
        rdata_ext = 32'h0;

        case (addr_lo)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (store_op)
            ST_SB: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            ST_SH: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            ST_SW: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: ;
        endcase

        if (load_op != LD_NONE)
            be = 4'b1111;

        case (load_op)
            LD_LB:   rdata_ext = {{24{rd_byte[7]}}, rd_byte};
            LD_LBU:  rdata_ext = {24'h0, rd_byte};
            LD_LH:   rdata_ext = {{16{rd_half[15]}}, rd_half};
            LD_LHU:  rdata_ext = {16'h0, rd_half};
            LD_LW:   rdata_ext = rdata;
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// MEM-stage load/store initiator: checks the access, runs one bus transaction, returns a response.
// Optional bus wait timeout is compiled in with `define LSU_TIMEOUT_EN.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_load,
    input  logic [1:0]  req_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_exc,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    lsu_state_e  state;
    logic [2:0]  lat_load;
    logic [1:0]  lat_store;
    logic [1:0]  lat_addr_lo;

    logic [2:0]  al_load;
    logic [1:0]  al_store;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic [4:0]  req_exc;

    // In IDLE the aligner shapes the incoming store; afterwards it extracts load data for the latched op.
    assign al_load    = (state == S_IDLE) ? req_load       : lat_load;
    assign al_store   = (state == S_IDLE) ? req_store      : lat_store;
    assign al_addr_lo = (state == S_IDLE) ? req_addr[1:0]  : lat_addr_lo;
    assign req_exc    = access_exc(req_load, req_store, req_addr);

    lsu_align u_align (
        .load_op   (al_load),
        .store_op  (al_store),
        .addr_lo   (al_addr_lo),
        .wdata     (req_wdata),
        .rdata     (bus_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
    logic unused_ok;
    assign unused_ok = ^req_pc;
`else
    logic unused_ok;
    assign unused_ok = ^{req_pc, TIMEOUT[0]};
`endif

    always_ff @(posedge clk) begin
        // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            lat_load    <= LD_NONE;
            lat_store   <= ST_NONE;
            lat_addr_lo <= 2'b00;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_be      <= 4'b0000;
            bus_wdata   <= 32'h0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'h0;
            resp_exc    <= EXC_NONE;
`ifdef LSU_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && (req_load != LD_NONE || req_store != ST_NONE)) begin
                        lat_load    <= req_load;
                        lat_store   <= req_store;
                        lat_addr_lo <= req_addr[1:0];
                        req_ready   <= 1'b0;
                        if (req_exc != EXC_NONE) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                            resp_exc   <= req_exc;
                        end else begin
                            state     <= S_BUS;
                            bus_req   <= 1'b1;
                            bus_we    <= (req_store != ST_NONE);
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_be    <= al_be;
                            bus_wdata <= al_wdata;
`ifdef LSU_TIMEOUT_EN
                            wait_cnt  <= '0;
`endif
                        end
                    end
                end
                S_BUS: begin
                    if (bus_ack) begin
                        state      <= S_RESP;
                        bus_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= al_rdata;
                        resp_exc   <= EXC_NONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt + 1'b1 == CNT_W'(TIMEOUT)) begin
                        state      <= S_RESP;
                        bus_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'h0;
                        resp_exc   <= (lat_store != ST_NONE) ? EXC_ADES : EXC_ADEL;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed self-checking bench for lsu_bus_master; the timeout case runs only with LSU_TIMEOUT_EN.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_load;
    logic [1:0]  req_store;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_exc;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
    lsu_bus_master #(.TIMEOUT(4)) dut (
`else
    lsu_bus_master dut (
`endif
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one request at a negedge; the following posedge is the accept edge T.
    task automatic issue(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1;
        req_load  = ld;
        req_store = st;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = 32'h0040_0000 + addr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_load  = 3'd0;
        req_store = 2'd0;
    endtask

    task automatic run_legal(input string tag, input logic [2:0] ld, input logic [1:0] st,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int waits,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                             input logic [31:0] exp_rdata);
        issue(ld, st, addr, wdata);
        // Now in cycle T+1: the bus phase, held for `waits` extra cycles before the ack.
        for (int i = 0; i <= waits; i++) begin
            check({tag, ".bus_req"},  32'(bus_req), 32'd1);
            check({tag, ".bus_we"},   32'(bus_we), 32'(st != 2'd0));
            check({tag, ".bus_addr"}, bus_addr, {addr[31:2], 2'b00});
            check({tag, ".bus_be"},   32'(bus_be), 32'(exp_be));
            if (st != 2'd0) check({tag, ".bus_wdata"}, bus_wdata, exp_wdata);
            check({tag, ".ready_lo"}, 32'(req_ready), 32'd0);
            check({tag, ".no_resp"},  32'(resp_valid), 32'd0);
            bus_ack   = (i == waits);
            bus_rdata = (i == waits) ? rdata : 32'hxxxx_xxxx;
            @(negedge clk);
        end
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
        check({tag, ".resp_exc"},   32'(resp_exc), 32'd0);
        check({tag, ".bus_req_lo"}, 32'(bus_req), 32'd0);
        @(negedge clk);
        check({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_illegal(input string tag, input logic [2:0] ld, input logic [1:0] st,
                               input logic [31:0] addr, input logic [4:0] exp_exc);
        issue(ld, st, addr, 32'hcafe_f00d);
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".resp_exc"},   32'(resp_exc), 32'(exp_exc));
        check({tag, ".resp_rdata"}, resp_rdata, 32'h0);
        check({tag, ".no_bus"},     32'(bus_req), 32'd0);
        check({tag, ".ready_lo"},   32'(req_ready), 32'd0);
        @(negedge clk);
        check({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, ".no_bus2"},    32'(bus_req), 32'd0);
        check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_load  = 3'd0;
        req_store = 2'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_pc    = 32'h0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.req_ready",  32'(req_ready), 32'd1);
        check("rst.bus_req",    32'(bus_req), 32'd0);
        check("rst.bus_we",     32'(bus_we), 32'd0);
        check("rst.bus_addr",   bus_addr, 32'h0);
        check("rst.bus_be",     32'(bus_be), 32'd0);
        check("rst.bus_wdata",  bus_wdata, 32'h0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'h0);
        check("rst.resp_exc",   32'(resp_exc), 32'd0);
        reset = 1'b0;

        //        tag      ld    st    addr          wdata         rdata         wait be       wdata         rdata
        run_legal("lw",    3'd5, 2'd0, 32'h0000_0010, 32'h0,        32'h8000_00ff, 0, 4'b1111, 32'h0,        32'h8000_00ff);
        run_legal("sb",    3'd0, 2'd1, 32'h0000_0003, 32'h0000_00a5, 32'hdead_beef, 0, 4'b1000, 32'ha5a5_a5a5, 32'h0);
        run_legal("lb",    3'd1, 2'd0, 32'h0000_0002, 32'h0,        32'h1280_0000, 0, 4'b1111, 32'h0,        32'hffff_ff80);
        run_legal("lhu",   3'd4, 2'd0, 32'h0000_0002, 32'h0,        32'h1280_0000, 0, 4'b1111, 32'h0,        32'h0000_1280);
        run_legal("lh",    3'd3, 2'd0, 32'h0000_0000, 32'h0,        32'h0000_9abc, 0, 4'b1111, 32'h0,        32'hffff_9abc);
        run_legal("lbu",   3'd2, 2'd0, 32'h0000_0101, 32'h0,        32'h0000_f100, 0, 4'b1111, 32'h0,        32'h0000_00f1);
        run_legal("sh",    3'd0, 2'd2, 32'h0000_2ffe, 32'h1234_abcd, 32'h0,        0, 4'b1100, 32'habcd_abcd, 32'h0);
        run_legal("sb0",   3'd0, 2'd1, 32'h0000_0004, 32'h0000_ff3c, 32'h0,        0, 4'b0001, 32'h3c3c_3c3c, 32'h0);
        run_legal("sw_t0", 3'd0, 2'd3, 32'h0000_7f00, 32'h1122_3344, 32'h0,        3, 4'b1111, 32'h1122_3344, 32'h0);
        run_legal("lw_t1", 3'd5, 2'd0, 32'h0000_7f18, 32'h0,        32'h0000_0042, 1, 4'b1111, 32'h0,        32'h0000_0042);

        run_illegal("lh_mis",  3'd3, 2'd0, 32'h0000_0001, 5'd4);
        run_illegal("sw_cnt",  3'd0, 2'd3, 32'h0000_7f08, 5'd5);
        run_illegal("sb_tmr",  3'd0, 2'd1, 32'h0000_7f04, 5'd5);
        run_illegal("lw_oom",  3'd5, 2'd0, 32'h0000_3000, 5'd4);
        run_illegal("sw_mis",  3'd0, 2'd3, 32'h0000_0002, 5'd5);
        run_illegal("lw_gap",  3'd5, 2'd0, 32'h0000_7f0c, 5'd4);
        run_illegal("sh_tmr",  3'd0, 2'd2, 32'h0000_7f10, 5'd5);
        run_illegal("lbu_tmr", 3'd2, 2'd0, 32'h0000_7f00, 5'd4);
        run_illegal("sw_oom",  3'd0, 2'd3, 32'h0000_7f1c, 5'd5);

        // Null request and a stray ack in IDLE both leave the master idle.
        @(negedge clk);
        req_valid = 1'b1;
        bus_ack   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        bus_ack   = 1'b0;
        check("null.ready",   32'(req_ready), 32'd1);
        check("null.no_resp", 32'(resp_valid), 32'd0);
        check("null.no_bus",  32'(bus_req), 32'd0);

        // Reset during BUS abandons the transaction.
        issue(3'd5, 2'd0, 32'h0000_0020, 32'h0);
        check("rstbus.bus_req", 32'(bus_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstbus.bus_drop", 32'(bus_req), 32'd0);
        check("rstbus.no_resp",  32'(resp_valid), 32'd0);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("rstbus.no_resp2", 32'(resp_valid), 32'd0);
        check("rstbus.ready",    32'(req_ready), 32'd1);

`ifdef LSU_TIMEOUT_EN
        issue(3'd0, 2'd3, 32'h0000_0100, 32'h5555_aaaa);
        for (int i = 0; i < 4; i++) begin
            check("tmo.bus_req", 32'(bus_req), 32'd1);
            @(negedge clk);
        end
        check("tmo.bus_drop",   32'(bus_req), 32'd0);
        check("tmo.resp_valid", 32'(resp_valid), 32'd1);
        check("tmo.resp_exc",   32'(resp_exc), 32'd5);
        @(negedge clk);
        check("tmo.ready",      32'(req_ready), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
